// File: rtl/b13_serial_rx_if.sv
// ----------------------------------------------------------------------------
// b13_serial_rx_if
// Purpose : Groups the serial line, the receive-buffer handshake and the status
//           flags of the b13 serial receiver into one bundle.
// Signals : serial_in  - serial line from the transmitter (idles high)
//           rx_ack     - consumer acknowledge of rx_data
//           rx_data    - last received byte (first data bit in bit 7)
//           rx_valid   - rx_data holds an unacknowledged byte
//           frame_err  - one-cycle pulse on a framing error
//           overrun    - sticky, a completed byte was dropped
//           dsr        - ready-to-receive indication back to the transmitter
//           busy       - receiver FSM is inside a frame
// Modports: slave  - the receiver itself
//           master - the environment (transmitter line + byte consumer)
// ----------------------------------------------------------------------------
interface b13_serial_rx_if;
  logic       serial_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       dsr;
  logic       busy;

  modport slave (
    input  serial_in,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output dsr,
    output busy
  );

  modport master (
    output serial_in,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  dsr,
    input  busy
  );
endinterface

// File: rtl/b13_serial_rx.sv
// ----------------------------------------------------------------------------
// b13_serial_rx
// Purpose : Receives frames produced by the b13 ADC-to-serial transmitter and
//           reassembles bytes into a one-entry buffer with a valid/ack
//           handshake. Frame: one-cycle low start pulse, 8 data bits MSB
//           first, stop bit 1; each bit is a one-cycle pulse every
//           P = DELAY_TIME+2 clocks, line idles high in between.
// Ports   : clock  - rising-edge clock
//           reset  - synchronous, active-high reset
//           bus    - b13_serial_rx_if.slave (serial_in, rx_ack, rx_data,
//                    rx_valid, frame_err, overrun, dsr, busy)
// Params  : DELAY_TIME - transmitter delay count, legal 1..1021
//           CNT_W      - width of the bit-timing counter
// Option  : B13_RX_GLITCH_CHECK_EN - when defined, a low on serial_in at any
//           non-sample edge inside a frame aborts the frame with frame_err.
// ----------------------------------------------------------------------------
module b13_serial_rx #(
  parameter int DELAY_TIME = 104,
  parameter int CNT_W      = 10
) (
  input  logic              clock,
  input  logic              reset,
  b13_serial_rx_if.slave    bus
);

  // Last counter value of a bit period; the sample edge is where cnt hits it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_TIME + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       rx_data_q,   rx_data_d;
  logic             rx_valid_q,  rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;
  logic             busy_q,      busy_d;
  logic             sample_s;
  logic             complete_s;

  // Frame FSM: start detection, bit timing, data shifting and stop check.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    complete_s  = 1'b0;
    sample_s    = (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
        if (bus.serial_in == 1'b0) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (sample_s) begin
          // Reload on the sample edge so cnt never exceeds CNT_LAST.
          cnt_d = {CNT_W{1'b0}};
          shift_d[3'd7 - bit_idx_q] = bus.serial_in;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef B13_RX_GLITCH_CHECK_EN
          // A low between sample points aborts the frame; it is not a start.
          if (bus.serial_in == 1'b0) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            cnt_d       = {CNT_W{1'b0}};
            bit_idx_d   = 3'd0;
          end else begin
            state_d = ST_DATA;
          end
`endif
        end
      end

      ST_STOP: begin
        if (sample_s) begin
          cnt_d     = {CNT_W{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = ST_IDLE;
          if (bus.serial_in == 1'b1) begin
            complete_s = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef B13_RX_GLITCH_CHECK_EN
          if (bus.serial_in == 1'b0) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            cnt_d       = {CNT_W{1'b0}};
            bit_idx_d   = 3'd0;
          end else begin
            state_d = ST_STOP;
          end
`endif
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Receive buffer: load on completion, clear on ack, flag dropped bytes.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;

    if (complete_s) begin
      // An ack on the completion edge frees the slot for the new byte.
      if ((rx_valid_q == 1'b0) || (bus.rx_ack == 1'b1)) begin
        rx_data_d  = shift_d;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if ((rx_valid_q == 1'b1) && (bus.rx_ack == 1'b1)) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;
  // dsr tracks the buffer combinationally so the transmitter sees it at once.
  assign bus.dsr       = ~rx_valid_q;

endmodule
